// File: rtl/coherence_bus_arbiter_if.sv
// Bus bundle between the N L1 D-caches, the coherence bus arbiter and dmem strobes.
// master = arbiter side, slave = cache/requester side.
interface coherence_bus_arbiter_if #(
  parameter int N_CPU  = 2,
  parameter int ADDR_W = 13
);
  localparam int CPU_IDX_W = (N_CPU > 1) ? $clog2(N_CPU) : 1;

  logic [N_CPU-1:0]        req_valid;
  logic [2*N_CPU-1:0]      req_op;
  logic [ADDR_W*N_CPU-1:0] req_addr;
  logic [N_CPU-1:0]        snoop_hit;
  logic [2*N_CPU-1:0]      snoop_state;
  logic [N_CPU-1:0]        grant;
  logic [N_CPU-1:0]        done;
  logic [ADDR_W-1:0]       bus_addr;
  logic [1:0]              bus_op;
  logic [N_CPU-1:0]        snoop_req;
  logic [N_CPU-1:0]        inv;
  logic [N_CPU-1:0]        downgrade;
  logic [1:0]              data_sel;
  logic [CPU_IDX_W-1:0]    fwd_src;
  logic                    dmem_re;
  logic                    dmem_we;
  logic                    coh_err;

  modport master (
    input  req_valid, req_op, req_addr, snoop_hit, snoop_state,
    output grant, done, bus_addr, bus_op, snoop_req, inv, downgrade,
           data_sel, fwd_src, dmem_re, dmem_we, coh_err
  );

  modport slave (
    output req_valid, req_op, req_addr, snoop_hit, snoop_state,
    input  grant, done, bus_addr, bus_op, snoop_req, inv, downgrade,
           data_sel, fwd_src, dmem_re, dmem_we, coh_err
  );
endinterface

// File: rtl/coherence_bus_arbiter.sv
// N-core MSI snoopy bus controller: arbitrate, snoop, pick data source (owner cache or dmem).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module coherence_bus_arbiter #(
  parameter int N_CPU    = 2,
  parameter int ADDR_W   = 13,
  parameter int DMEM_LAT = 4
) (
  input logic                    clk,
  input logic                    rst,
  coherence_bus_arbiter_if.master bus
);
  localparam int CPU_IDX_W = (N_CPU > 1) ? $clog2(N_CPU) : 1;
  localparam int CNT_W     = (DMEM_LAT > 1) ? $clog2(DMEM_LAT) : 1;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_INV   = 2'b10;
  localparam logic [1:0] OP_WB    = 2'b11;

  localparam logic [1:0] SEL_DMEM = 2'b00;
  localparam logic [1:0] SEL_CPU  = 2'b01;
  localparam logic [1:0] SEL_NONE = 2'b11;

  localparam logic [1:0] MSI_I = 2'b00;
  localparam logic [1:0] MSI_S = 2'b01;
  localparam logic [1:0] MSI_M = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_SNOOP, S_RESOLVE, S_XFER, S_MEM, S_DONE
  } state_t;

  state_t               state, res_next;
  logic [N_CPU-1:0]     grant_q, done_q, snoop_req_q;
  logic [N_CPU-1:0]     eff_hit, m_hit, s_hit, res_inv, res_dg;
  logic [CPU_IDX_W-1:0] win_idx, cand, m_lo, s_lo, res_src, fwd_src_q;
  logic                 win_found, res_we, m_multi, in_resolve;
  logic [1:0]           op_q, win_op, res_sel, data_sel_q;
  logic [ADDR_W-1:0]    addr_q, win_addr;
  logic [CNT_W-1:0]     cnt;
  logic                 dmem_re_q, dmem_we_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic [CPU_IDX_W-1:0] rr_ptr;
`endif

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_CPU; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      cand = CPU_IDX_W'((int'(rr_ptr) + k) % N_CPU);
`else
      cand = CPU_IDX_W'(k);
`endif
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_op   = bus.req_op[2*int'(win_idx) +: 2];
    win_addr = bus.req_addr[ADDR_W*int'(win_idx) +: ADDR_W];
  end

  // Owner's own snoop bits are masked; a hit reporting I is treated as a miss.
  always_comb begin
    eff_hit = '0;
    m_hit   = '0;
    s_hit   = '0;
    m_lo    = '0;
    s_lo    = '0;
    for (int i = 0; i < N_CPU; i++) begin
      eff_hit[i] = bus.snoop_hit[i] && !grant_q[i] && (bus.snoop_state[2*i +: 2] != MSI_I);
      m_hit[i]   = eff_hit[i] && (bus.snoop_state[2*i +: 2] == MSI_M);
      s_hit[i]   = eff_hit[i] && (bus.snoop_state[2*i +: 2] == MSI_S);
    end
    for (int i = N_CPU - 1; i >= 0; i--) begin
      if (m_hit[i]) m_lo = CPU_IDX_W'(i);
      if (s_hit[i]) s_lo = CPU_IDX_W'(i);
    end
    m_multi = |(m_hit & (m_hit - N_CPU'(1)));
  end

  always_comb begin
    res_inv  = '0;
    res_dg   = '0;
    res_we   = 1'b0;
    res_sel  = SEL_NONE;
    res_src  = '0;
    res_next = S_DONE;
    case (op_q)
      OP_READ: begin
        if (|m_hit) begin
          res_dg   = N_CPU'(1) << m_lo;
          res_we   = 1'b1;
          res_sel  = SEL_CPU;
          res_src  = m_lo;
          res_next = S_XFER;
        end else if (|s_hit) begin
          res_sel  = SEL_CPU;
          res_src  = s_lo;
          res_next = S_XFER;
        end else begin
          res_sel  = SEL_DMEM;
          res_next = S_MEM;
        end
      end
      OP_WRITE: begin
        res_inv = eff_hit;
        if (|m_hit) begin
          res_sel  = SEL_CPU;
          res_src  = m_lo;
          res_next = S_XFER;
        end else begin
          res_sel  = SEL_DMEM;
          res_next = S_MEM;
        end
      end
      OP_INV: begin
        res_inv = eff_hit;
      end
      default: ;
    endcase
  end

  assign in_resolve    = (state == S_RESOLVE);
  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_op    = op_q;
  assign bus.snoop_req = snoop_req_q;
  assign bus.inv       = in_resolve ? res_inv : '0;
  assign bus.downgrade = in_resolve ? res_dg  : '0;
  assign bus.coh_err   = in_resolve && m_multi;
  assign bus.data_sel  = in_resolve ? res_sel : data_sel_q;
  assign bus.fwd_src   = in_resolve ? res_src : fwd_src_q;
  assign bus.dmem_re   = dmem_re_q;
  assign bus.dmem_we   = dmem_we_q || (in_resolve && res_we);

  // NOTE: all state uses non-blocking assignments; reset is synchronous and covers every register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      snoop_req_q <= '0;
      dmem_re_q   <= 1'b0;
      dmem_we_q   <= 1'b0;
      data_sel_q  <= SEL_NONE;
      fwd_src_q   <= '0;
      addr_q      <= '0;
      op_q        <= OP_READ;
      cnt         <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr      <= '0;
`endif
    end else begin
      done_q      <= '0;
      snoop_req_q <= '0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant_q <= N_CPU'(1) << win_idx;
            op_q    <= win_op;
            addr_q  <= win_addr;
            cnt     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr  <= (int'(win_idx) == N_CPU - 1) ? '0 : win_idx + 1'b1;
`endif
            if (win_op == OP_WB) begin
              dmem_we_q <= 1'b1;
              state     <= S_MEM;
            end else begin
              snoop_req_q <= ~(N_CPU'(1) << win_idx);
              state       <= S_SNOOP;
            end
          end
        end
        S_SNOOP: state <= S_RESOLVE;
        S_RESOLVE: begin
          data_sel_q <= res_sel;
          fwd_src_q  <= res_src;
          state      <= res_next;
          if (res_next == S_MEM) dmem_re_q <= 1'b1;
          if (res_next == S_DONE) done_q <= grant_q;
        end
        S_XFER: begin
          done_q <= grant_q;
          state  <= S_DONE;
        end
        S_MEM: begin
          if (cnt == CNT_W'(DMEM_LAT - 1)) begin
            dmem_re_q <= 1'b0;
            dmem_we_q <= 1'b0;
            done_q    <= grant_q;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          grant_q    <= '0;
          data_sel_q <= SEL_NONE;
          fwd_src_q  <= '0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed bench for coherence_bus_arbiter: a 2-core and a 4-core instance, DMEM_LAT=4.
// Grant order expectation follows ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_coherence_bus_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  coherence_bus_arbiter_if #(.N_CPU(2), .ADDR_W(13)) if2 ();
  coherence_bus_arbiter_if #(.N_CPU(4), .ADDR_W(13)) if4 ();

  coherence_bus_arbiter #(.N_CPU(2), .ADDR_W(13), .DMEM_LAT(4)) dut2 (
    .clk(clk), .rst(rst), .bus(if2)
  );
  coherence_bus_arbiter #(.N_CPU(4), .ADDR_W(13), .DMEM_LAT(4)) dut4 (
    .clk(clk), .rst(rst), .bus(if4)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [3:0] rr_exp [5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    rst = 1'b1;
    if2.req_valid = '0; if2.req_op = '0; if2.req_addr = '0;
    if2.snoop_hit = '0; if2.snoop_state = '0;
    if4.req_valid = '0; if4.req_op = '0; if4.req_addr = '0;
    if4.snoop_hit = '0; if4.snoop_state = '0;

    // Reset values
    tick(2);
    check("rst_grant", if2.grant, 0);
    check("rst_done", if2.done, 0);
    check("rst_data_sel", if2.data_sel, 2'b11);
    check("rst_dmem_re", if2.dmem_re, 0);
    check("rst_snoop_req", if2.snoop_req, 0);
    check("rst4_data_sel", if4.data_sel, 2'b11);
    rst = 1'b0;
    tick();

    // Read miss cpu0, no effective hits (cpu1 reports hit with state I)
    if2.req_valid = 2'b01; if2.req_op = 4'b0000; if2.req_addr[12:0] = 13'h1A3;
    tick();
    check("t1_grant", if2.grant, 2'b01);
    check("t1_snoop_req", if2.snoop_req, 2'b10);
    check("t1_bus_addr", if2.bus_addr, 13'h1A3);
    tick();
    if2.snoop_hit = 2'b10; if2.snoop_state = 4'b0000; #1;
    check("t1_sel_c2", if2.data_sel, 2'b00);
    check("t1_inv_c2", if2.inv, 0);
    check("t1_dmem_re_c2", if2.dmem_re, 0);
    tick();
    if2.snoop_hit = '0;
    for (int c = 3; c <= 6; c++) begin
      check($sformatf("t1_dmem_re_c%0d", c), if2.dmem_re, 1);
      check($sformatf("t1_done_c%0d", c), if2.done, 0);
      tick();
    end
    check("t1_done_c7", if2.done, 2'b01);
    check("t1_dmem_re_c7", if2.dmem_re, 0);
    check("t1_sel_c7", if2.data_sel, 2'b00);
    if2.req_valid = '0;
    tick();
    check("t1_idle_grant", if2.grant, 0);
    check("t1_idle_sel", if2.data_sel, 2'b11);

    // Read miss cpu1, cpu0 holds the line in M
    if2.req_valid = 2'b10; if2.req_op = 4'b0000; if2.req_addr[25:13] = 13'h0F0;
    tick();
    check("t2_grant", if2.grant, 2'b10);
    check("t2_snoop_req", if2.snoop_req, 2'b01);
    tick();
    if2.snoop_hit = 2'b01; if2.snoop_state = 4'b0010; #1;
    check("t2_downgrade", if2.downgrade, 2'b01);
    check("t2_dmem_we", if2.dmem_we, 1);
    check("t2_sel", if2.data_sel, 2'b01);
    check("t2_fwd_src", if2.fwd_src, 0);
    check("t2_inv", if2.inv, 0);
    tick();
    if2.snoop_hit = '0; if2.snoop_state = '0; #1;
    check("t2_downgrade_c3", if2.downgrade, 0);
    check("t2_dmem_we_c3", if2.dmem_we, 0);
    check("t2_sel_c3", if2.data_sel, 2'b01);
    check("t2_done_c3", if2.done, 0);
    tick();
    check("t2_done_c4", if2.done, 2'b10);
    if2.req_valid = '0;
    tick();

    // Write miss cpu0, cpu1 holds S
    if2.req_valid = 2'b01; if2.req_op = 4'b0001; if2.req_addr[12:0] = 13'h055;
    tick();
    check("t3_snoop_req", if2.snoop_req, 2'b10);
    check("t3_bus_op", if2.bus_op, 2'b01);
    tick();
    if2.snoop_hit = 2'b10; if2.snoop_state = 4'b0100; #1;
    check("t3_inv", if2.inv, 2'b10);
    check("t3_sel", if2.data_sel, 2'b00);
    check("t3_downgrade", if2.downgrade, 0);
    tick();
    if2.snoop_hit = '0; if2.snoop_state = '0; #1;
    check("t3_inv_c3", if2.inv, 0);
    check("t3_dmem_re_c3", if2.dmem_re, 1);
    tick(3);
    check("t3_dmem_re_c6", if2.dmem_re, 1);
    tick();
    check("t3_done_c7", if2.done, 2'b01);
    check("t3_dmem_re_c7", if2.dmem_re, 0);
    if2.req_valid = '0;
    tick();

    // INVALIDATE cpu1; cpu0 in S, owner's own M report must be ignored
    if2.req_valid = 2'b10; if2.req_op = 4'b1000; if2.req_addr[25:13] = 13'h1FF;
    tick();
    check("t4_snoop_req", if2.snoop_req, 2'b01);
    tick();
    if2.snoop_hit = 2'b11; if2.snoop_state = 4'b1001; #1;
    check("t4_inv", if2.inv, 2'b01);
    check("t4_coh_err", if2.coh_err, 0);
    check("t4_sel", if2.data_sel, 2'b11);
    check("t4_downgrade", if2.downgrade, 0);
    tick();
    if2.snoop_hit = '0; if2.snoop_state = '0;
    check("t4_done_c3", if2.done, 2'b10);
    if2.req_valid = '0;
    tick();
    check("t4_idle_grant", if2.grant, 0);

    // WRITEBACK cpu0: no snoop, dmem_we for 4 cycles, done @5
    if2.req_valid = 2'b01; if2.req_op = 4'b0011; if2.req_addr[12:0] = 13'h0AA;
    tick();
    check("t5_dmem_we_c1", if2.dmem_we, 1);
    check("t5_snoop_req_c1", if2.snoop_req, 0);
    check("t5_grant_c1", if2.grant, 2'b01);
    tick(3);
    check("t5_dmem_we_c4", if2.dmem_we, 1);
    check("t5_done_c4", if2.done, 0);
    tick();
    check("t5_done_c5", if2.done, 2'b01);
    check("t5_dmem_we_c5", if2.dmem_we, 0);
    if2.req_valid = '0;
    tick();

    // Reset during MEM aborts the op; a fresh request is then accepted
    if2.req_valid = 2'b01; if2.req_op = 4'b0000; if2.req_addr[12:0] = 13'h1A3;
    tick(4);
    check("t6_dmem_re_c4", if2.dmem_re, 1);
    rst = 1'b1;
    tick();
    check("t6_rst_grant", if2.grant, 0);
    check("t6_rst_dmem_re", if2.dmem_re, 0);
    check("t6_rst_sel", if2.data_sel, 2'b11);
    check("t6_rst_done", if2.done, 0);
    rst = 1'b0;
    if2.req_valid = 2'b10; if2.req_op = 4'b0000;
    tick();
    check("t6_new_grant", if2.grant, 2'b10);
    check("t6_new_snoop_req", if2.snoop_req, 2'b01);
    check("t6_new_done", if2.done, 0);
    tick(6);
    check("t6_new_done_c7", if2.done, 2'b10);
    if2.req_valid = '0;
    tick();

    // 4 cores, all requests held: grant order
    if4.req_valid = 4'hF; if4.req_op = 8'h00;
    if4.req_addr = {13'h004, 13'h003, 13'h002, 13'h001};
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("arb_grant_%0d", k), if4.grant, rr_exp[k]);
      tick(6);
      check($sformatf("arb_done_%0d", k), if4.done, rr_exp[k]);
      tick();
    end

    // 4 cores: cpu0 read, cpu1 and cpu2 both report M
    if4.req_valid = 4'b0001; if4.req_op = 8'h00;
    tick();
    check("coh_snoop_req", if4.snoop_req, 4'b1110);
    tick();
    if4.snoop_hit = 4'b0110; if4.snoop_state = 8'b00_10_10_00; #1;
    check("coh_err_c2", if4.coh_err, 1);
    check("coh_fwd_src_c2", if4.fwd_src, 1);
    check("coh_downgrade_c2", if4.downgrade, 4'b0010);
    check("coh_dmem_we_c2", if4.dmem_we, 1);
    check("coh_sel_c2", if4.data_sel, 2'b01);
    tick();
    if4.snoop_hit = '0; if4.snoop_state = '0; #1;
    check("coh_err_c3", if4.coh_err, 0);
    check("coh_fwd_src_c3", if4.fwd_src, 1);
    tick();
    check("coh_done_c4", if4.done, 4'b0001);
    if4.req_valid = '0;
    tick();
    check("coh_idle_grant", if4.grant, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
